// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with one-entry skid buffer, sync flush and post-reset hold
//   clk, rst (async, active-high)  clock and reset
//   flush                          synchronous discard of all held beats (ignored during hold)
//   in_valid/in_ready/in_data      upstream handshake; in_ready is registered
//   out_valid/out_ready/out_data   downstream handshake; out_valid and out_data are registered
//   hold_active                    high while the post-reset hold window runs
module pipe_stage_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int RESET_HOLD = 1,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  hold_active
);
  localparam int CW = RESET_HOLD > 0 ? $clog2(RESET_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_MAX = CW'(RESET_HOLD);
  localparam logic [1:0] S_HOLD  = 2'd0;
  localparam logic [1:0] S_EMPTY = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;
  localparam logic [1:0] S_SKID  = 2'd3;
  localparam logic [1:0] S_INIT  = RESET_HOLD > 0 ? S_HOLD : S_EMPTY;

  logic [1:0]            r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_main, r_skid;
  logic                  r_skid_valid, r_in_ready, r_out_valid, r_hold;
  logic                  w_in_fire, w_out_fire, w_flush;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;
  assign w_flush    = flush & (r_state != S_HOLD);

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_main;
  assign hold_active = r_hold;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HOLD:  w_next = (r_cnt + 1'b1 == HOLD_MAX) ? S_EMPTY : S_HOLD;
      S_EMPTY: w_next = w_in_fire ? S_FULL : S_EMPTY;
      S_FULL:  w_next = w_out_fire ? (w_in_fire ? S_FULL : S_EMPTY) : (w_in_fire ? S_SKID : S_FULL);
      default: w_next = w_out_fire ? S_FULL : S_SKID;
    endcase
    if (w_flush) w_next = S_EMPTY;
  end

  // Handshake outputs are registered from the next state so in_ready never
  // depends combinationally on out_ready; the skid absorbs the in-flight beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_INIT;
      r_cnt        <= '0;
      r_main       <= RESET_VALUE;
      r_skid       <= RESET_VALUE;
      r_skid_valid <= 1'b0;
      r_in_ready   <= RESET_HOLD == 0;
      r_out_valid  <= 1'b0;
      r_hold       <= RESET_HOLD > 0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == S_EMPTY) || (w_next == S_FULL);
      r_out_valid <= (w_next == S_FULL) || (w_next == S_SKID);
      r_hold      <= w_next == S_HOLD;
      if (r_cnt != HOLD_MAX) r_cnt <= r_cnt + 1'b1;
      if (w_flush) begin
        r_main       <= RESET_VALUE;
        r_skid_valid <= 1'b0;
      end else begin
        if (w_in_fire && (r_state == S_EMPTY || w_out_fire)) r_main <= in_data;
        else if (r_skid_valid && w_out_fire) r_main <= r_skid;
        if (w_in_fire && r_state == S_FULL && !w_out_fire) begin
          r_skid       <= in_data;
          r_skid_valid <= 1'b1;
        end else if (r_skid_valid && w_out_fire) r_skid_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg at two configurations
module tb_pipe_stage_reg;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", n, a, e);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int W  = g == 0 ? 8 : 64;
    localparam int RH = g == 0 ? 2 : 0;
    localparam logic [W-1:0] RV = W'(g == 0 ? 64'hA5 : 64'hDEAD_BEEF_0123_4567);
    logic rst, flush, in_valid, in_ready, out_valid, out_ready, hold_active, fin, pend;
    logic [W-1:0] in_data, out_data, pd, last;
    logic [W-1:0] q[$];
    int hold_rem;

    pipe_stage_reg #(.DATA_WIDTH(W), .RESET_HOLD(RH), .RESET_VALUE(RV)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .hold_active(hold_active)
    );

    // One clock of stimulus; a beat accepted at an edge becomes expected output after it.
    task automatic cyc(input logic v, input logic [63:0] d, input logic f, input logic r);
      @(posedge clk);
      if (pend) q.push_back(pd);
      pend = 1'b0;
      #1;
      in_valid = v;
      in_data = W'(d);
      flush = f;
      out_ready = r;
      if (v && in_ready && !f) begin
        pend = 1'b1;
        pd = W'(d);
      end
    endtask

    task automatic rst_pulse();
      #2 rst = 1'b1;
      pend = 1'b0;
      #1;
      chk($sformatf("w%0d async rst out_valid", W), out_valid, 0);
      chk($sformatf("w%0d async rst out_data", W), out_data, RV);
      chk($sformatf("w%0d async rst in_ready", W), in_ready, RH == 0);
      chk($sformatf("w%0d async rst hold_active", W), hold_active, RH != 0);
      q.delete();
      hold_rem = RH;
      last = RV;
      @(posedge clk);
      #1 rst = 1'b0;
      if (in_valid && in_ready && !flush) begin
        pend = 1'b1;
        pd = in_data;
      end
    endtask

    // Reference: occupancy = queue size (0 empty, 1 full, 2 skid); outputs follow from it.
    always @(negedge clk) if (!rst) begin
      chk($sformatf("w%0d in_ready", W), in_ready, hold_rem == 0 && q.size() < 2);
      chk($sformatf("w%0d out_valid", W), out_valid, q.size() != 0);
      chk($sformatf("w%0d hold_active", W), hold_active, hold_rem != 0);
      chk($sformatf("w%0d out_data", W), out_data, q.size() != 0 ? q[0] : last);
      if (flush && hold_rem == 0) begin
        q.delete();
        last = RV;
      end else if (out_valid && out_ready && q.size() != 0) last = q.pop_front();
      if (hold_rem > 0) hold_rem--;
    end

    initial begin
      fin = 1'b0; rst = 1'b0; flush = 1'b0; pend = 1'b0;
      in_valid = 1'b1; in_data = W'(64'h77); out_ready = 1'b1;
      hold_rem = RH; last = RV;
      rst_pulse();
      for (int i = 0; i < RH + 2; i++) cyc(1, 64'h77, 0, 1);
      for (int i = 1; i <= 12; i++) cyc(1, i, 0, 1);
      cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
      cyc(1, 64'hA, 0, 1); cyc(1, 64'hB, 0, 0); cyc(1, 64'hC, 0, 0); cyc(1, 64'hC, 0, 0);
      cyc(1, 64'hC, 0, 1); cyc(1, 64'hC, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
      cyc(1, 64'h11, 0, 1); cyc(1, 64'h22, 0, 0); cyc(1, 64'h33, 1, 0);
      cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
      cyc(1, 64'h55, 0, 0);
      rst_pulse();
      for (int i = 0; i < RH + 2; i++) cyc(0, 0, 0, 1);
      for (int i = 0; i < 10000; i++) begin
        cyc($urandom % 4 != 0, {$urandom, $urandom}, $urandom % 97 == 0, $urandom % 3 != 0);
        if ($urandom % 2500 == 0) rst_pulse();
      end
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
      fin = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 30000 && !(gen_dut[0].fin && gen_dut[1].fin); i++) @(posedge clk);
    if (!(gen_dut[0].fin && gen_dut[1].fin)) begin
      checks++;
      errors++;
      $display("FAIL timeout: finished=%b%b, required 11", gen_dut[1].fin, gen_dut[0].fin);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
